// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the iterative signed multiply/divide sequencer.
// FSM state encoding, op encoding and the default operand width.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MULT = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic OP_MULT   = 1'b0;
    localparam logic OP_DIV    = 1'b1;
    localparam int   DEF_WIDTH = 32;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 Booth step and one unsigned restoring-divide step, purely combinational.
// Zero latency; no flow control, the caller decides which result to keep.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] mplr,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   booth_acc,
    output logic [WIDTH-1:0] booth_mplr,
    output logic             booth_q_m1,
    output logic [WIDTH-1:0] div_rem,
    output logic [WIDTH-1:0] div_quo
);

    logic [WIDTH:0] mcand_ext;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // One guard bit on the accumulator keeps acc - (-2^(W-1)) from overflowing.
    assign mcand_ext = {mcand[WIDTH-1], mcand};

    always_comb begin
        sum = acc;
        case ({mplr[0], q_m1})
            2'b01:   sum = acc + mcand_ext;
            2'b10:   sum = acc - mcand_ext;
            default: sum = acc;
        endcase
        booth_acc  = {sum[WIDTH], sum[WIDTH:1]};
        booth_mplr = {sum[0], mplr[WIDTH-1:1]};
        booth_q_m1 = mplr[0];
    end

    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    always_comb begin
        if (diff[WIDTH]) begin
            div_rem = shifted[WIDTH-1:0];
            div_quo = {quo[WIDTH-2:0], 1'b0};
        end else begin
            div_rem = diff[WIDTH-1:0];
            div_quo = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for signed MULT/DIV into Hi/Lo: MULT done WIDTH+1 cycles after start, DIV WIDTH+2, DIV by zero 1.
// No queueing: start is only sampled in IDLE, anything else is dropped.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             hilo_we
);

    state_t state, state_n;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [WIDTH-1:0] m;
    logic             sign_a, sign_b, dz;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic [WIDTH:0]   booth_acc;
    logic [WIDTH-1:0] booth_mplr, div_rem, div_quo;
    logic             booth_q_m1;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             last;

    // Magnitudes are unsigned, so -2^(W-1) maps to 2^(W-1) without overflow.
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;
    assign last  = (cnt == CNT_W'(1));

    // The accumulator and q register double as remainder and quotient during DIV.
    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc        (acc),
        .mplr       (q),
        .q_m1       (q_m1),
        .mcand      (m),
        .rem        (acc[WIDTH-1:0]),
        .quo        (q),
        .divisor    (m),
        .booth_acc  (booth_acc),
        .booth_mplr (booth_mplr),
        .booth_q_m1 (booth_q_m1),
        .div_rem    (div_rem),
        .div_quo    (div_quo)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: state_n = S_MULT;
                        default: state_n = (b == '0) ? S_DONE : S_DIV;
                    endcase
                end
            end
            S_MULT:  if (last) state_n = S_DONE;
            S_DIV:   if (last) state_n = S_FIX;
            S_FIX:   state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            q_m1   <= 1'b0;
            m      <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dz     <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt  <= CNT_W'(WIDTH);
                        acc  <= '0;
                        q_m1 <= 1'b0;
                        dz   <= 1'b0;
                        if (op == OP_MULT) begin
                            q <= b;
                            m <= a;
                        end else if (b == '0) begin
                            dz <= 1'b1;
                        end else begin
                            q      <= a_mag;
                            m      <= b_mag;
                            sign_a <= a[WIDTH-1];
                            sign_b <= b[WIDTH-1];
                        end
                    end
                end
                S_MULT: begin
                    acc  <= booth_acc;
                    q    <= booth_mplr;
                    q_m1 <= booth_q_m1;
                    cnt  <= cnt - CNT_W'(1);
                    if (last) begin
                        hi_q <= booth_acc[WIDTH-1:0];
                        lo_q <= booth_mplr;
                    end
                end
                S_DIV: begin
                    acc <= {1'b0, div_rem};
                    q   <= div_quo;
                    cnt <= cnt - CNT_W'(1);
                end
                S_FIX: begin
                    lo_q <= (sign_a ^ sign_b) ? -q : q;
                    hi_q <= sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign div_zero = done && dz;
    assign hilo_we  = done && !dz;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl: a queue of expected results from a plain-arithmetic model,
// drained by an independent monitor whenever the DUT signals completion.
module tb_muldiv_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero, hilo_we;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        bit           dz;
        int           start_cyc;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           n_issued = 0;
    int           n_done = 0;
    logic [W-1:0] mdl_hi = '0;
    logic [W-1:0] mdl_lo = '0;

    muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo),
        .hilo_we  (hilo_we)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: signed 64-bit arithmetic; SV division already truncates toward zero.
    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic signed [63:0] sx, sy, r;
        sx = 64'($signed(x));
        sy = 64'($signed(y));
        e.dz = 1'b0;
        e.start_cyc = 0;
        if (!o) begin
            r    = sx * sy;
            e.hi = r[63:32];
            e.lo = r[31:0];
            e.lat = W + 1;
        end else if (y == '0) begin
            e.dz  = 1'b1;
            e.hi  = mdl_hi;
            e.lo  = mdl_lo;
            e.lat = 1;
        end else begin
            r    = sx / sy;
            e.lo = r[31:0];
            r    = sx % sy;
            e.hi = r[31:0];
            e.lat = W + 2;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'h8000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h0000_0000;
            3:       v = 32'($urandom_range(0, 20)) - 32'd10;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input bit expect_it);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (expect_it) begin
            e = model(o, x, y);
            e.start_cyc = cyc + 1;
            if (!e.dz) begin
                mdl_hi = e.hi;
                mdl_lo = e.lo;
            end
            sb.push_back(e);
            n_issued++;
        end
        @(negedge clk);
        start = 1'b0;
        op    = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // Returns at the negedge of the DONE cycle; optionally pokes a start there, which must be dropped.
    task automatic wait_idle(input bit poke_done);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout_waiting_done", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        if (poke_done) begin
            start = 1'b1;
            op    = 1'b1;
            b     = '0;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done || hilo_we || div_zero) begin
                n_done++;
                if (sb.size() == 0) begin
                    check("spurious_done", 64'({done, hilo_we, div_zero}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("hi", 64'(hi), 64'(e.hi));
                    check("lo", 64'(lo), 64'(e.lo));
                    check("div_zero", 64'(div_zero), 64'(e.dz));
                    check("hilo_we", 64'(hilo_we), 64'(!e.dz));
                    check("done", 64'(done), 64'd1);
                    check("busy_in_done", 64'(busy), 64'd1);
                    check("latency", 64'(cyc - e.start_cyc + 1), 64'(e.lat));
                end
            end
        end
    end

    initial begin : stim
        rst   = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        check("rst_hilo_we", 64'(hilo_we), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        issue(1'b0, 32'd7, -32'sd3, 1'b1);                 wait_idle(1'b0);
        issue(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1);   wait_idle(1'b0);
        issue(1'b1, -32'sd7, 32'd2, 1'b1);                 wait_idle(1'b0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);   wait_idle(1'b0);
        issue(1'b1, 32'd5, 32'd0, 1'b1);                   wait_idle(1'b0);

        // Start during MULT is dropped; start in the DONE cycle is dropped too.
        issue(1'b0, 32'd12345, -32'sd678, 1'b1);
        repeat (8) @(negedge clk);
        check("busy_mid_mult", 64'(busy), 64'd1);
        start = 1'b1;
        op    = 1'b1;
        b     = '0;
        @(negedge clk);
        start = 1'b0;
        wait_idle(1'b1);
        check("idle_after_done_poke", 64'(busy), 64'd0);

        // Back-to-back: next start lands the cycle after done.
        issue(1'b1, 32'd100, -32'sd7, 1'b1);
        wait_idle(1'b0);
        issue(1'b0, -32'sd1, -32'sd1, 1'b1);
        wait_idle(1'b0);

        // Reset mid-DIV: no result, outputs cleared.
        issue(1'b1, 32'd999, 32'd4, 1'b0);
        repeat (13) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mdl_hi = '0;
        mdl_lo = '0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (40) @(negedge clk);
        check("abort_still_idle", 64'(busy), 64'd0);

        issue(1'b1, 32'd9, 32'd0, 1'b1);                   wait_idle(1'b0);

        for (int i = 0; i < 40; i++) begin
            logic         o;
            logic [W-1:0] x, y;
            o = 1'($urandom);
            x = rnd_operand();
            y = rnd_operand();
            issue(o, x, y, 1'b1);
            wait_idle(1'b0);
        end

        repeat (5) @(negedge clk);
        check("done_count", 64'(n_done), 64'(n_issued));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
